riscv_regfile_wb: RTL and testbench
===================================

RISCV_REGFILE_WB -- requirements
Module: riscv_regfile_wb

Interface
REQ-001 Parameter: n, 32, datapath and register width in bits.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset; the block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-004 Port: instruction_R  input  n  current instruction: rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0].
REQ-005 Port: valid_in  input  1  instruction_R is a live issue this cycle.
REQ-006 Port: ALUResult_R  input  n  ALU result for the current instruction, same cycle.
REQ-007 Port: Read_data1_R  output  n  rs1 operand to the ALU, combinational.
REQ-008 Port: Read_data2_R  output  n  rs2 operand to the ALU, combinational.
REQ-009 Port: wb_valid  output  1  writeback stage holds a pending write.
REQ-010 Port: wb_rd  output  5  writeback destination register.
REQ-011 Port: wb_data  output  n  writeback data.
REQ-012 Port: retire_cnt  output  32  count of committed writes.

Function
REQ-013 Storage SHALL be 32 registers x0..x31, each n bits.
REQ-014 x0 SHALL always read 0, and any write to x0 SHALL be discarded.
REQ-015 Read_data1_R and Read_data2_R SHALL be combinational reads of rs1 and rs2, independent of valid_in.
REQ-016 Capture SHALL occur at each rising edge.
- wb_valid <= valid_in AND opcode==0110011 AND rd!=0.
- wb_rd <= rd.
- wb_data <= ALUResult_R.
REQ-017 Commit SHALL occur at each rising edge: if wb_valid is 1, reg[wb_rd] <= wb_data and retire_cnt increments by 1.
REQ-018 Issue-to-architectural-write latency SHALL be 2 edges: the capture edge, then the commit edge.
REQ-019 Commit of the old stage and capture of the new stage on the same edge SHALL both take effect.
REQ-020 A non-R-type opcode, or valid_in=0, SHALL capture wb_valid=0 and cause no commit.
REQ-021 retire_cnt SHALL wrap from 0xFFFFFFFF to 0 without flagging.
REQ-022 A read of the register being committed on the same edge SHALL return the old value before the edge and the new value after it.

Reset
REQ-023 While rst_n=0, the block SHALL asynchronously clear all of the following to 0:
- all 32 registers;
- wb_valid, wb_rd, wb_data;
- retire_cnt.
REQ-024 Reset asserted mid-operation SHALL drop any pending write, and that write SHALL never commit.
REQ-025 After reset release, the first capture SHALL occur on the first rising edge with rst_n=1.

Configuration
REQ-026 Macro RF_BYPASS_EN SHALL control operand bypass from the writeback stage.
REQ-027 With RF_BYPASS_EN defined:
- if wb_valid=1 and wb_rd==rs1 (rs1!=0), Read_data1_R SHALL equal wb_data;
- the same rule SHALL apply to rs2 and Read_data2_R;
- the combinational path adds one 5-bit compare and one mux per port.
REQ-028 Without RF_BYPASS_EN, reads SHALL return array contents only, so a back-to-back dependent instruction sees the stale value.

Verification
REQ-029 Scenario: reset, then issue add x1 with ALUResult_R=5 -> wb_valid=1, wb_rd=1, wb_data=5 after edge 1; reg x1=5 and retire_cnt=1 after edge 2.
REQ-030 Scenario: back-to-back, write x4=0xD, then next cycle read rs1=x4 -> Read_data1_R=0xD with RF_BYPASS_EN; previous value (0 after reset) without it.
REQ-031 Scenario: R-type with rd=0 and ALUResult_R=0xFFFF -> wb_valid=0, x0 reads 0, retire_cnt unchanged.
REQ-032 Scenario: opcode 0010011 with valid_in=1, or R-type with valid_in=0 -> no commit, retire_cnt unchanged.
REQ-033 Scenario: rst_n pulsed low between the capture edge and the commit edge of a write to x6=0x23 -> x6 stays 0, wb_valid=0 immediately, retire_cnt=0.
REQ-034 Scenario: retire_cnt preloaded by force to 0xFFFFFFFF, then one commit -> retire_cnt=0.

Source files
------------

// File: rtl/riscv_regfile_wb.sv
// riscv_regfile_wb: 32 x n register file with one-stage R-type writeback and a commit counter.
// Optional RF_BYPASS_EN forwards the pending writeback data to matching operand reads.
module riscv_regfile_wb #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] instruction_R,
  input  logic         valid_in,
  input  logic [n-1:0] ALUResult_R,
  output logic [n-1:0] Read_data1_R,
  output logic [n-1:0] Read_data2_R,
  output logic         wb_valid,
  output logic [4:0]   wb_rd,
  output logic [n-1:0] wb_data,
  output logic [31:0]  retire_cnt
);
  localparam logic [6:0] R_TYPE = 7'b0110011;
  logic [n-1:0] r_regs [32];
  logic         r_wb_valid;
  logic [4:0]   r_wb_rd;
  logic [n-1:0] r_wb_data;
  logic [31:0]  r_retire_cnt;
  logic [4:0]   w_rs1, w_rs2, w_rd;
  logic [n-1:0] w_arr1, w_arr2;
  logic         w_unused;
  assign w_rs1    = instruction_R[19:15];
  assign w_rs2    = instruction_R[24:20];
  assign w_rd     = instruction_R[11:7];
  assign w_unused = ^{instruction_R[n-1:25], instruction_R[14:12]};
  assign w_arr1   = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_arr2   = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
`ifdef RF_BYPASS_EN
  assign Read_data1_R = (r_wb_valid && r_wb_rd == w_rs1 && w_rs1 != 5'd0) ? r_wb_data : w_arr1;
  assign Read_data2_R = (r_wb_valid && r_wb_rd == w_rs2 && w_rs2 != 5'd0) ? r_wb_data : w_arr2;
`else
  assign Read_data1_R = w_arr1;
  assign Read_data2_R = w_arr2;
`endif
  // commit of the held write and capture of the new one share the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_wb_valid <= valid_in && instruction_R[6:0] == R_TYPE && w_rd != 5'd0;
      r_wb_rd    <= w_rd;
      r_wb_data  <= ALUResult_R;
      if (r_wb_valid) begin
        r_regs[r_wb_rd] <= r_wb_data;
        r_retire_cnt    <= r_retire_cnt + 32'd1;
      end
    end
  end
  assign wb_valid   = r_wb_valid;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign retire_cnt = r_retire_cnt;
endmodule

// File: tb/tb_riscv_regfile_wb.sv
// tb_riscv_regfile_wb: directed vectors, a pending-write model checked every cycle, plus literal scenario checks.
module tb_riscv_regfile_wb;
  localparam logic [6:0] R = 7'b0110011;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        clk, rst_n, valid_in;
  logic [31:0] instruction_R, ALUResult_R, Read_data1_R, Read_data2_R, wb_data, retire_cnt;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  int checks = 0, errors = 0;
  riscv_regfile_wb #(.n(32)) dut (
    .clk(clk), .rst_n(rst_n), .instruction_R(instruction_R), .valid_in(valid_in),
    .ALUResult_R(ALUResult_R), .Read_data1_R(Read_data1_R), .Read_data2_R(Read_data2_R),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .retire_cnt(retire_cnt)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  function automatic logic [31:0] mk(input logic [4:0] rd, rs1, rs2, input logic [6:0] op);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: architectural registers, one in-flight write, committed-write count
  logic [31:0] m_reg [32];
  logic        m_pv;
  logic [4:0]  m_prd;
  logic [31:0] m_pd, m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_reg[i]) m_reg[i] = 0;
      m_pv = 0; m_prd = 0; m_pd = 0; m_cnt = 0;
    end else begin
      if (m_pv) begin
        m_reg[m_prd] = m_pd;
        m_cnt = m_cnt + 1;
      end
      m_pv  = valid_in && instruction_R[6:0] == R && instruction_R[11:7] != 0;
      m_prd = instruction_R[11:7];
      m_pd  = ALUResult_R;
    end
  end
  function automatic logic [31:0] m_read(input logic [4:0] rs);
    if (rs == 0) return 0;
    if (BYP && m_pv && m_prd == rs) return m_pd;
    return m_reg[rs];
  endfunction
  always @(negedge clk) begin
    chk("rd1", Read_data1_R, m_read(instruction_R[19:15]));
    chk("rd2", Read_data2_R, m_read(instruction_R[24:20]));
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_pv});
    chk("wb_rd", {27'd0, wb_rd}, {27'd0, m_prd});
    chk("wb_data", wb_data, m_pd);
    chk("retire_cnt", retire_cnt, m_cnt);
  end
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] alu);
    @(posedge clk);
    #2;
    valid_in = v; instruction_R = ins; ALUResult_R = alu;
  endtask
  initial begin
    rst_n = 0; valid_in = 0; instruction_R = 0; ALUResult_R = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    chk("L reset wb_valid", {31'd0, wb_valid}, 0);
    chk("L reset retire", retire_cnt, 0);
    drive(1, mk(1, 0, 0, R), 5);
    drive(0, mk(0, 1, 0, R), 0);
    chk("L add wb_valid", {31'd0, wb_valid}, 1);
    chk("L add wb_rd", {27'd0, wb_rd}, 1);
    chk("L add wb_data", wb_data, 5);
    chk("L add retire0", retire_cnt, 0);
    drive(0, mk(0, 1, 0, R), 0);
    chk("L add x1", Read_data1_R, 5);
    chk("L add retire1", retire_cnt, 1);
    drive(1, mk(4, 0, 0, R), 32'hD);
    drive(0, mk(0, 4, 4, R), 0);
    chk("L b2b rd1", Read_data1_R, BYP ? 32'hD : 32'h0);
    chk("L b2b rd2", Read_data2_R, BYP ? 32'hD : 32'h0);
    drive(0, mk(0, 4, 4, R), 0);
    chk("L b2b x4", Read_data1_R, 32'hD);
    chk("L b2b retire", retire_cnt, 2);
    drive(1, mk(0, 0, 0, R), 32'hFFFF);
    drive(0, mk(0, 0, 0, R), 0);
    chk("L x0 wb_valid", {31'd0, wb_valid}, 0);
    chk("L x0 read", Read_data1_R, 0);
    drive(0, mk(0, 0, 0, R), 0);
    chk("L x0 retire", retire_cnt, 2);
    drive(1, mk(5, 0, 0, 7'b0010011), 7);
    drive(0, mk(5, 0, 0, R), 9);
    chk("L itype wb_valid", {31'd0, wb_valid}, 0);
    drive(0, mk(0, 5, 0, 7'd0), 0);
    chk("L novalid wb_valid", {31'd0, wb_valid}, 0);
    drive(0, mk(0, 5, 0, 7'd0), 0);
    chk("L nocommit x5", Read_data1_R, 0);
    chk("L nocommit retire", retire_cnt, 2);
    drive(1, mk(6, 0, 0, R), 32'h23);
    drive(0, mk(0, 6, 1, 7'd0), 0);
    rst_n = 0;
    #1;
    chk("L rst wb_valid", {31'd0, wb_valid}, 0);
    chk("L rst retire", retire_cnt, 0);
    chk("L rst x1", Read_data2_R, 0);
    #1 rst_n = 1;
    drive(0, mk(0, 6, 0, 7'd0), 0);
    chk("L rst x6", Read_data1_R, 0);
    chk("L rst retire after", retire_cnt, 0);
    drive(1, mk(7, 0, 0, R), 32'h11);
    drive(0, mk(0, 7, 0, 7'd0), 0);
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_retire_cnt;
    drive(0, mk(0, 7, 0, 7'd0), 0);
    chk("L wrap retire", retire_cnt, 0);
    chk("L wrap x7", Read_data1_R, 32'h11);
    for (int i = 0; i < 8; i++) drive(1, mk(5'(i + 2), 5'(i + 1), 5'(i), R), 32'h1000 * i + 32'h55);
    for (int i = 0; i < 10; i++) drive(0, mk(0, 5'(i), 5'(i + 1), R), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
